// File: rtl/snapshot_ctrl.sv
// Triggered capture of a sample stream into a block RAM write port.
// Define SNAPSHOT_TIMESTAMP_EN to latch a free-running cycle count at trigger.
module snapshot_ctrl #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic [31:0]             config_snapshot,
  input  logic [31:0]             offset_snapshot,
  input  logic [SAMPLE_WIDTH-1:0] din,
  input  logic                    din_valid,
  input  logic                    ext_trig,
  output logic                    bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [SAMPLE_WIDTH-1:0] bram_din,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             trig_timestamp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DELAY,
    S_CAP,
    S_DONE
  } state_t;

  localparam logic [31:0] MAX_IDX =
    32'((64'd1 << ADDR_WIDTH) - 64'd1);

  state_t                state_q;
  state_t                state_d;
  logic                  armed;
  logic                  arm_prev;
  logic                  hist_ok;
  logic                  arm_start;
  logic                  trig_take;
  logic                  cap_beat;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [31:0]           offset_q;
  logic [31:0]           dly_cnt;
  logic [31:0]           off_eff;
  logic [31:0]           len_field;
  logic [31:0]           len_clamp;

  assign armed = config_snapshot[0];

  // hist_ok masks the first cycle out of reset so a held level is not an edge
  assign arm_start = armed & ~arm_prev & hist_ok;

  assign len_field = {16'd0, config_snapshot[31:16]};
  assign len_clamp = (len_field > MAX_IDX) ? MAX_IDX : len_field;

  assign off_eff = (state_q == S_IDLE) ? offset_snapshot : offset_q;

  assign busy = (state_q == S_WAIT) | (state_q == S_DELAY) |
                (state_q == S_CAP);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    trig_take = 1'b0;
    cap_beat  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm_start) begin
          if (config_snapshot[1]) state_d = S_WAIT;
          else                    trig_take = 1'b1;
        end
      end
      S_WAIT: begin
        if (!armed)        state_d = S_IDLE;
        else if (ext_trig) trig_take = 1'b1;
      end
      S_DELAY: begin
        if (!armed) state_d = S_IDLE;
        else if (din_valid && dly_cnt == offset_q - 32'd1)
          state_d = S_CAP;
      end
      S_CAP: begin
        if (!armed) state_d = S_IDLE;
        else if (din_valid) begin
          cap_beat = 1'b1;
          if (wr_cnt == last_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!armed) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (trig_take)
      state_d = (off_eff != 32'd0) ? S_DELAY : S_CAP;
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arm_prev  <= 1'b0;
      hist_ok   <= 1'b0;
      last_q    <= '0;
      offset_q  <= '0;
      dly_cnt   <= '0;
      wr_cnt    <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      state_q  <= state_d;
      arm_prev <= armed;
      hist_ok  <= 1'b1;
      if (state_q == S_IDLE && arm_start) begin
        last_q   <= len_clamp[ADDR_WIDTH-1:0];
        offset_q <= offset_snapshot;
      end
      if (trig_take)
        dly_cnt <= '0;
      else if (state_q == S_DELAY && din_valid)
        dly_cnt <= dly_cnt + 32'd1;
      if (trig_take)     wr_cnt <= '0;
      else if (cap_beat) wr_cnt <= wr_cnt + 1'b1;
      bram_we <= cap_beat;
      if (cap_beat) begin
        bram_addr <= wr_cnt;
        bram_din  <= din;
      end
    end
  end

`ifdef SNAPSHOT_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      ts_cnt         <= '0;
      trig_timestamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trig_take) trig_timestamp <= ts_cnt;
    end
  end
`else
  assign trig_timestamp = 32'd0;
`endif

endmodule
